// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one N:1 data mux between N requesters and
// presents the selected word on a valid/ready channel. Optional macro: MUX_ARB_BURST_EN.
module mux_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   grant,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] g_idx_s;
    logic [W-1:0]  mux_s;
    logic [PW-1:0] win_cur_s;
    logic [PW-1:0] win_next_s;
    logic          valid_s;
    logic          xfer_s;
    logic          rotate_s;

    // First requester found scanning base+1, base+2, ... modulo N; base itself is checked last.
    function automatic logic [PW-1:0] pick_winner(input logic [N-1:0] r, input logic [PW-1:0] base);
        logic [PW-1:0] sel;
        logic [PW-1:0] cand;
        logic          found;
        sel   = {PW{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(base) + k) % N);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [PW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Grant index decode and AND-OR data mux; an all-zero grant yields zero data.
    always_comb begin
        g_idx_s = {PW{1'b0}};
        mux_s   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                g_idx_s = PW'(i);
            end else begin
                g_idx_s = g_idx_s;
            end
            mux_s = mux_s | (req_data[i*W +: W] & {W{grant[i]}});
        end
    end

    assign win_cur_s  = pick_winner(req, ptr_r);
    assign win_next_s = pick_winner(req, g_idx_s);
    assign valid_s    = (state_r == GRANT) && ((req & grant) != {N{1'b0}});
    assign xfer_s     = valid_s && out_ready;

`ifdef MUX_ARB_BURST_EN
    // Only the closing beat of a burst releases the grant.
    assign rotate_s = xfer_s && req_last[g_idx_s];
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;
    assign rotate_s      = xfer_s;
`endif

    assign out_valid = valid_s;
    assign out_data  = mux_s;

    // Arbitration state machine: grant is held until release or abort, never preempted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            grant   <= {N{1'b0}};
            ptr_r   <= PW'(N - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != {N{1'b0}}) begin
                        grant   <= to_onehot(win_cur_s);
                        state_r <= GRANT;
                    end else begin
                        grant   <= {N{1'b0}};
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (rotate_s) begin
                        ptr_r <= g_idx_s;
                        if (req != {N{1'b0}}) begin
                            grant   <= to_onehot(win_next_s);
                            state_r <= GRANT;
                        end else begin
                            grant   <= {N{1'b0}};
                            state_r <= IDLE;
                        end
                    end else if (!valid_s) begin
                        // Granted requester withdrew before transfer: release, pointer untouched.
                        grant   <= {N{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        grant   <= grant;
                        state_r <= GRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant   <= {N{1'b0}};
                    ptr_r   <= PW'(N - 1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks;
    int failures;

    mux_rr_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req       = 4'b0000;
        req_last  = 4'b0000;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req_data = 32'h44332211;
        do_reset();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b exp 0000", grant); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h exp 00", out_data); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL idle_grant[%0d]: got %b exp 0000", i, grant); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid[%0d]: got %b exp 0", i, out_valid); end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_g = 4'b0001 << (i % 4);
            exp_d = 8'h10 + 8'(i % 4);
            checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant[%0d]: got %b exp %b", i, grant, exp_g); end
            checks++; if ((grant & (grant - 4'd1)) !== 4'd0) begin failures++; $display("FAIL rr_onehot[%0d]: got %b exp one-hot", i, grant); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_data !== exp_d) begin failures++; $display("FAIL rr_data[%0d]: got %h exp %h", i, out_data, exp_d); end
        end
    endtask

    task automatic test_stall;
        do_reset();
        req_data  = {8'h55, 8'hC2, 8'h55, 8'hA0};
        req       = 4'b0101;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL stall_grant[%0d]: got %b exp 0001", i, grant); end
            checks++; if (out_data !== 8'hA0) begin failures++; $display("FAIL stall_data[%0d]: got %h exp a0", i, out_data); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b exp 1", i, out_valid); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL stall_next_grant: got %b exp 0100", grant); end
        checks++; if (out_data !== 8'hC2) begin failures++; $display("FAIL stall_next_data: got %h exp c2", out_data); end
    endtask

    task automatic test_no_preempt;
        do_reset();
        req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL np_first: got %b exp 0100", grant); end
        req = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL np_hold[%0d]: got %b exp 0100", i, grant); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL np_rotate: got %b exp 0001", grant); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL np_data: got %h exp 00", out_data); end
    endtask

    task automatic test_abort;
        do_reset();
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req       = 4'b0100;
        out_ready = 1'b0;
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL abort_grant: got %b exp 0100", grant); end
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL abort_release: got %b exp 0000", grant); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL abort_data: got %h exp 00", out_data); end
        // With the pointer still at 3, requester 2 beats requester 3.
        req = 4'b1100;
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL abort_regrant: got %b exp 0100", grant); end
        checks++; if (out_data !== 8'hC2) begin failures++; $display("FAIL abort_regrant_data: got %h exp c2", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL abort_after_xfer: got %b exp 1000", grant); end
        checks++; if (out_data !== 8'hD3) begin failures++; $display("FAIL abort_after_data: got %h exp d3", out_data); end
    endtask

    task automatic test_single;
        do_reset();
        req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        req       = 4'b0010;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL single_grant[%0d]: got %b exp 0010", i, grant); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL single_data[%0d]: got %h exp 5a", i, out_data); end
        end
    endtask

    task automatic test_back_to_back_burst;
        logic [3:0] exp_g [4];
        logic [3:0] last_seq [4];
        logic [7:0] exp_d;
`ifdef MUX_ARB_BURST_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        last_seq = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        do_reset();
        req_data  = {8'h00, 8'h00, 8'hB1, 8'hB0};
        req       = 4'b0011;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_last = last_seq[i];
            exp_d = (exp_g[i] == 4'b0001) ? 8'hB0 : 8'hB1;
            checks++; if (grant !== exp_g[i]) begin failures++; $display("FAIL burst_grant[%0d]: got %b exp %b", i, grant, exp_g[i]); end
            checks++; if (out_data !== exp_d) begin failures++; $display("FAIL burst_data[%0d]: got %h exp %h", i, out_data, exp_d); end
        end
    endtask

    task automatic test_reset_in_flight;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req       = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rif_pre: got %b exp 0010", grant); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rif_grant: got %b exp 0000", grant); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rif_valid: got %b exp 0", out_valid); end
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rif_restart: got %b exp 0001", grant); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h00000000;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_stall();
        test_no_preempt();
        test_abort();
        test_single();
        test_back_to_back_burst();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
